// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output buffer: drain FSM states and a
// bit-reversal function used to produce natural-order spectra.
package fft_pkg;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Reverses the low 'width' bits of val; the bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res = {res[30:0], val[i[4:0]]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_out_bank.sv
// One half-depth result bank: simple dual-port RAM with one write port and one
// synchronous read port whose output holds between read enables.
module fft_out_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_q;

    // Memory array and read register are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_mem_out.sv
// FFT output result buffer: fills two banks (k, k+N/2) then drains N words over
// valid/ready. Define FFT_OUT_BITREV_EN to drain in bit-reversed address order.
module fft_mem_out
    import fft_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [RAM_ADDR_BITS-2:0] wr_addr_i,
    input  logic [RAM_WIDTH-1:0]     data_i_1,
    input  logic [RAM_WIDTH-1:0]     data_i_2,
    input  logic                     frame_done_i,
    output logic                     wr_ready_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [RAM_WIDTH-1:0]     rd_data_o,
    output logic                     rd_last_o
);

    localparam int BANK_AW = RAM_ADDR_BITS - 1;
    localparam logic [RAM_ADDR_BITS:0] CNT_END  = {1'b1, {RAM_ADDR_BITS{1'b0}}};
    localparam logic [RAM_ADDR_BITS:0] CNT_LAST = {1'b0, {RAM_ADDR_BITS{1'b1}}};
    localparam logic [RAM_ADDR_BITS:0] CNT_ONE  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [RAM_ADDR_BITS:0]   rd_cnt_q, rd_cnt_d;
    logic                     pend_q, pend_d;
    logic                     sel_q, sel_d;
    logic                     last_pipe_q, last_pipe_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     rd_last_q, rd_last_d;
    logic [RAM_WIDTH-1:0]     rd_data_q, rd_data_d;

    logic                     issue_s;
    logic                     load_s;
    logic                     hs_s;
    logic                     bank_we_s;
    logic [RAM_ADDR_BITS-1:0] phys_s;
    logic [RAM_WIDTH-1:0]     rdata1_s;
    logic [RAM_WIDTH-1:0]     rdata2_s;

    // Maps the logical drain index onto a physical point address.
    always_comb begin
`ifdef FFT_OUT_BITREV_EN
        phys_s = RAM_ADDR_BITS'(bitrev(32'(rd_cnt_q[RAM_ADDR_BITS-1:0]), RAM_ADDR_BITS));
`else
        phys_s = rd_cnt_q[RAM_ADDR_BITS-1:0];
`endif
    end

    // pend_q marks a word sitting in the bank read registers but not yet in the
    // output register; RAM outputs hold, so a stalled word is never lost.
    assign hs_s      = rd_valid_q && rd_ready_i;
    assign issue_s   = (state_q == ST_DRAIN) && (rd_cnt_q < CNT_END) && (!rd_valid_q || rd_ready_i);
    assign load_s    = pend_q && (!rd_valid_q || rd_ready_i);
    assign bank_we_s = (state_q == ST_FILL) && wr_en_i;

    fft_out_bank #(.WIDTH(RAM_WIDTH), .ADDR_W(BANK_AW)) u_bank1 (
        .clk_i     (clk_i),
        .wr_en_i   (bank_we_s),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (data_i_1),
        .rd_en_i   (issue_s),
        .rd_addr_i (phys_s[BANK_AW-1:0]),
        .rd_data_o (rdata1_s)
    );

    fft_out_bank #(.WIDTH(RAM_WIDTH), .ADDR_W(BANK_AW)) u_bank2 (
        .clk_i     (clk_i),
        .wr_en_i   (bank_we_s),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (data_i_2),
        .rd_en_i   (issue_s),
        .rd_addr_i (phys_s[BANK_AW-1:0]),
        .rd_data_o (rdata2_s)
    );

    // Next-state for FSM, read counter, read pipeline and output register.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        pend_d      = pend_q;
        sel_d       = sel_q;
        last_pipe_d = last_pipe_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            ST_FILL: begin
                if (frame_done_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (hs_s && rd_last_q) begin
                    state_d  = ST_FILL;
                    rd_cnt_d = '0;
                end else if (issue_s) begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            default: begin
                state_d  = ST_FILL;
                rd_cnt_d = '0;
            end
        endcase

        if (issue_s) begin
            pend_d      = 1'b1;
            sel_d       = phys_s[RAM_ADDR_BITS-1];
            last_pipe_d = (rd_cnt_q == CNT_LAST);
        end else if (load_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (load_s) begin
            rd_data_d  = sel_q ? rdata2_s : rdata1_s;
            rd_valid_d = 1'b1;
            rd_last_d  = last_pipe_q;
        end else if (hs_s) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
            rd_last_d  = rd_last_q;
        end
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_FILL;
            rd_cnt_q    <= '0;
            pend_q      <= 1'b0;
            sel_q       <= 1'b0;
            last_pipe_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            last_pipe_q <= last_pipe_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign wr_ready_o = (state_q == ST_FILL);
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_fft_mem_out.sv
// Directed bench for fft_mem_out with N=16: drain order, backpressure, writes
// during drain, reset mid-drain and a write coinciding with frame_done.
module tb_fft_mem_out;

    logic       clk_i;
    logic       rst_ni;
    logic       wr_en_i;
    logic [2:0] wr_addr_i;
    logic [7:0] data_i_1;
    logic [7:0] data_i_2;
    logic       frame_done_i;
    logic       wr_ready_o;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic [7:0] rd_data_o;
    logic       rd_last_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] mdl [16];

    fft_mem_out #(.RAM_WIDTH(8), .RAM_ADDR_BITS(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .data_i_1     (data_i_1),
        .data_i_2     (data_i_2),
        .frame_done_i (frame_done_i),
        .wr_ready_o   (wr_ready_o),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_last_o    (rd_last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ord(input int i);
`ifdef FFT_OUT_BITREV_EN
        return int'({i[0], i[1], i[2], i[3]});
`else
        return i;
`endif
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the write edge.
    task automatic wr_pair(input int k, input logic [7:0] d1, input logic [7:0] d2, input logic fd);
        wr_en_i      = 1'b1;
        wr_addr_i    = 3'(k);
        data_i_1     = d1;
        data_i_2     = d2;
        frame_done_i = fd;
        mdl[k]       = d1;
        mdl[k + 8]   = d2;
        @(negedge clk_i);
        wr_en_i      = 1'b0;
        frame_done_i = 1'b0;
    endtask

    // Entered at the negedge after frame_done was sampled.
    task automatic wait_first();
        @(negedge clk_i);
        wr_en_i      = 1'b0;
        frame_done_i = 1'b0;
        check_vec("lat1_valid", 32'(rd_valid_o), 32'd0);
        @(negedge clk_i);
        check_vec("first_valid", 32'(rd_valid_o), 32'd1);
    endtask

    task automatic frame_start(input logic inject);
        frame_done_i = 1'b1;
        @(negedge clk_i);
        frame_done_i = 1'b0;
        check_vec("drain_wr_ready", 32'(wr_ready_o), 32'd0);
        check_vec("lat0_valid", 32'(rd_valid_o), 32'd0);
        if (inject) begin
            wr_en_i      = 1'b1;
            wr_addr_i    = 3'd0;
            data_i_1     = 8'hAA;
            data_i_2     = 8'hBB;
            frame_done_i = 1'b1;
        end
        wait_first();
    endtask

    // Consumes 'stop' words, stalling 'stall_len' cycles on word 'stall_idx'.
    task automatic drain(input int stall_idx, input int stall_len, input int stop);
        int got = 0;
        int cyc = 0;
        int stall = 0;
        logic [7:0] held = 8'h00;
        while (got < stop && cyc < 100) begin
            if (rd_valid_o) begin
                if (got == stall_idx && stall < stall_len) begin
                    if (stall > 0) check_vec("stall_hold", 32'(rd_data_o), 32'(held));
                    held       = rd_data_o;
                    rd_ready_i = 1'b0;
                    stall++;
                end else begin
                    rd_ready_i = 1'b1;
                    check_vec($sformatf("word%0d", got), 32'(rd_data_o), 32'(mdl[ord(got)]));
                    check_vec($sformatf("last%0d", got), 32'(rd_last_o), (got == 15) ? 32'd1 : 32'd0);
                    if (got == 3) check_vec("mid_wr_ready", 32'(wr_ready_o), 32'd0);
                    got++;
                end
            end else begin
                rd_ready_i = 1'b1;
                check_vec("no_bubble", 32'(rd_valid_o), 32'd1);
            end
            cyc++;
            @(negedge clk_i);
        end
        if (cyc >= 100) check_vec("drain_timeout", 32'(got), 32'(stop));
    endtask

    task automatic post_frame();
        check_vec("post_valid", 32'(rd_valid_o), 32'd0);
        check_vec("post_last", 32'(rd_last_o), 32'd0);
        check_vec("post_wr_ready", 32'(wr_ready_o), 32'd1);
    endtask

    initial begin
        rst_ni       = 1'b0;
        wr_en_i      = 1'b0;
        wr_addr_i    = 3'd0;
        data_i_1     = 8'h00;
        data_i_2     = 8'h00;
        frame_done_i = 1'b0;
        rd_ready_i   = 1'b1;
        repeat (2) @(negedge clk_i);
        check_vec("rst_valid", 32'(rd_valid_o), 32'd0);
        check_vec("rst_data", 32'(rd_data_o), 32'd0);
        check_vec("rst_last", 32'(rd_last_o), 32'd0);
        check_vec("rst_wr_ready", 32'(wr_ready_o), 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Frame 1: d1=k, d2=k+8, full-rate drain.
        for (int k = 0; k < 8; k++) wr_pair(k, 8'(k), 8'(k + 8), 1'b0);
        frame_start(1'b0);
        drain(-1, 0, 16);
        post_frame();

        // Frame 2: pair 0 rewritten during drain must be ignored; stall on word 5.
        for (int k = 0; k < 8; k++) wr_pair(k, 8'(8'h20 + k), 8'(8'h28 + k), 1'b0);
        frame_start(1'b1);
        drain(5, 3, 16);
        post_frame();

        // Frame 3: reset after six words.
        for (int k = 0; k < 8; k++) wr_pair(k, 8'(8'h40 + k), 8'(8'h50 + k), 1'b0);
        frame_start(1'b0);
        drain(-1, 0, 6);
        rst_ni = 1'b0;
        #1;
        check_vec("arst_valid", 32'(rd_valid_o), 32'd0);
        check_vec("arst_last", 32'(rd_last_o), 32'd0);
        check_vec("arst_data", 32'(rd_data_o), 32'd0);
        check_vec("arst_wr_ready", 32'(wr_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Frame 4: final pair written on the frame_done cycle.
        for (int k = 0; k < 7; k++) wr_pair(k, 8'(8'h60 + k), 8'(8'h70 + k), 1'b0);
        wr_pair(7, 8'h77, 8'hFF, 1'b1);
        check_vec("f4_wr_ready", 32'(wr_ready_o), 32'd0);
        wait_first();
        drain(-1, 0, 16);
        post_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
